// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter8_dec3to8.sv
// 3-to-8 one-hot decoder with enable; index 0 drives the leftmost bit of Y.
module dec3to8
  import rr_arbiter8_pkg::*;
(
  input  logic [IDXW-1:0] W,
  input  logic            En,
  output logic [0:NREQ-1] Y
);

  always_comb begin
    Y = '0;
    if (En) Y[W] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per grant.
// state | meaning
// IDLE  | no owner; arbitrate from Ptr and grant on the next edge
// GRANT | Owner holds the resource until Done, request drop or hold limit
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAXHOLD = 15,
  parameter int CW      = 4
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [0:NREQ-1] R,
  input  logic            Done,
  output logic [0:NREQ-1] G,
  output logic [IDXW-1:0] Owner,
  output logic            Busy,
  output logic            Timeout
);

  state_e          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [IDXW-1:0] owner, owner_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            timeout_q, timeout_nxt;

  logic [0:NREQ-1] rot;
  logic [IDXW-1:0] off;
  logic [IDXW-1:0] pick;
  logic [IDXW-1:0] k;
  logic            any_req;
  logic            rel_req;
  logic            at_limit;

  // Rotate so Ptr sits at position 0, find the first request, rotate back.
  always_comb begin
    rot = '0;
    k   = '0;
    for (int j = 0; j < NREQ; j++) begin
      k      = ptr + IDXW'(j);
      rot[j] = R[k];
    end
    off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IDXW'(j);
    end
    pick    = ptr + off;
    any_req = |R;
  end

  assign rel_req  = Done | ~R[owner];
  assign at_limit = (cnt == CW'(MAXHOLD - 1));

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (rel_req || at_limit) begin
          state_nxt   = IDLE;
          ptr_nxt     = owner + IDXW'(1);
          // Only a pure hold-limit expiry counts as a forced release.
          timeout_nxt = ~rel_req;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      cnt       <= cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign Busy    = (state == GRANT);
  assign Owner   = owner;
  assign Timeout = timeout_q;

  dec3to8 u_dec (
    .W  (Owner),
    .En (Busy),
    .Y  (G)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench: hand-derived vector table, hand sequences for the hold
// limit, and a reference-model scoreboard under random traffic.
module tb_rr_arbiter8;

  typedef struct packed {
    logic [0:7] g;
    logic [2:0] owner;
    logic       busy;
    logic       to;
  } exp_t;

  typedef struct packed {
    logic       busy;
    logic [2:0] ptr;
    logic [2:0] owner;
    logic [3:0] cnt;
    logic       to;
  } mdl_t;

  typedef struct {
    logic       rstn;
    logic [0:7] r;
    logic       done;
    exp_t       e;
  } vec_t;

  logic       Clock;
  logic       rstn_a, done_a, rstn_b, done_b;
  logic [0:7] r_a, r_b;
  logic [0:7] g_a, g_b4, g_b1;
  logic [2:0] owner_a, owner_b4, owner_b1;
  logic       busy_a, busy_b4, busy_b1;
  logic       to_a, to_b4, to_b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t q_a[$];
  exp_t q_b4[$];
  exp_t q_b1[$];
  vec_t tbl[$];
  mdl_t m_a, m_b4, m_b1;

  rr_arbiter8 dut_a (
    .Clock(Clock), .Resetn(rstn_a), .R(r_a), .Done(done_a),
    .G(g_a), .Owner(owner_a), .Busy(busy_a), .Timeout(to_a)
  );

  rr_arbiter8 #(.MAXHOLD(4), .CW(4)) dut_b4 (
    .Clock(Clock), .Resetn(rstn_b), .R(r_b), .Done(done_b),
    .G(g_b4), .Owner(owner_b4), .Busy(busy_b4), .Timeout(to_b4)
  );

  rr_arbiter8 #(.MAXHOLD(1), .CW(4)) dut_b1 (
    .Clock(Clock), .Resetn(rstn_b), .R(r_b), .Done(done_b),
    .G(g_b1), .Owner(owner_b1), .Busy(busy_b1), .Timeout(to_b1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

  function automatic logic [0:7] oh(input logic [2:0] i);
    logic [0:7] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic exp_t mk(input logic [0:7] g, input logic [2:0] o,
                              input logic b, input logic t);
    exp_t e;
    e.g = g; e.owner = o; e.busy = b; e.to = t;
    return e;
  endfunction

  function automatic exp_t mout(input mdl_t m);
    return mk(m.busy ? oh(m.owner) : 8'h00, m.owner, m.busy, m.to);
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic rstn,
                                 input logic [0:7] r, input logic done,
                                 input int maxhold);
    mdl_t n;
    logic found;
    logic [2:0] idx;
    n    = m;
    n.to = 1'b0;
    if (!rstn) return '0;
    if (!m.busy) begin
      found = 1'b0;
      for (int s = 0; s < 8; s++) begin
        idx = 3'((int'(m.ptr) + s) % 8);
        if (!found && r[idx]) begin
          found   = 1'b1;
          n.busy  = 1'b1;
          n.owner = idx;
          n.cnt   = '0;
        end
      end
    end else if (done || !r[m.owner]) begin
      n.busy = 1'b0;
      n.ptr  = 3'((int'(m.owner) + 1) % 8);
    end else if (int'(m.cnt) == maxhold - 1) begin
      n.busy = 1'b0;
      n.ptr  = 3'((int'(m.owner) + 1) % 8);
      n.to   = 1'b1;
    end else begin
      n.cnt = m.cnt + 4'd1;
    end
    return n;
  endfunction

  function automatic void add(input logic rstn, input logic [0:7] r,
                              input logic done, input exp_t e);
    vec_t v;
    v.rstn = rstn; v.r = r; v.done = done; v.e = e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got g=%b owner=%0d busy=%b to=%b want g=%b owner=%0d busy=%b to=%b",
               nm, cyc, act.g, act.owner, act.busy, act.to,
               exp.g, exp.owner, exp.busy, exp.to);
    end
  endtask

  task automatic drive_a(input logic rstn, input logic [0:7] r, input logic done,
                         input logic use_exp, input exp_t e);
    rstn_a = rstn; r_a = r; done_a = done;
    m_a = mstep(m_a, rstn, r, done, 15);
    q_a.push_back(use_exp ? e : mout(m_a));
  endtask

  task automatic drive_b(input logic rstn, input logic [0:7] r, input logic done,
                         input logic use_exp, input exp_t e);
    rstn_b = rstn; r_b = r; done_b = done;
    m_b4 = mstep(m_b4, rstn, r, done, 4);
    m_b1 = mstep(m_b1, rstn, r, done, 1);
    q_b4.push_back(use_exp ? e : mout(m_b4));
    q_b1.push_back(mout(m_b1));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge Clock);
    #1;
    cyc++;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("arb15", {g_a, owner_a, busy_a, to_a}, e);
    end
    if (q_b4.size() > 0) begin
      e = q_b4.pop_front();
      chk("arb4", {g_b4, owner_b4, busy_b4, to_b4}, e);
    end
    if (q_b1.size() > 0) begin
      e = q_b1.pop_front();
      chk("arb1", {g_b1, owner_b1, busy_b1, to_b1}, e);
    end
  endtask

  initial begin
    logic [2:0] nx;
    exp_t z;
    z = '0;
    m_a = '0; m_b4 = '0; m_b1 = '0;
    rstn_a = 1'b0; r_a = 8'hFF; done_a = 1'b1;
    rstn_b = 1'b0; r_b = 8'h00; done_b = 1'b0;

    // Reset with everything requesting, then full rotation 0..7,0.
    add(1'b0, 8'hFF, 1'b1, mk(8'h00, 3'd0, 1'b0, 1'b0));
    add(1'b0, 8'hFF, 1'b1, mk(8'h00, 3'd0, 1'b0, 1'b0));
    add(1'b1, 8'hFF, 1'b0, mk(8'b10000000, 3'd0, 1'b1, 1'b0));
    for (int k = 0; k < 8; k++) begin
      nx = 3'((k + 1) % 8);
      add(1'b1, 8'hFF, 1'b1, mk(8'h00, 3'(k), 1'b0, 1'b0));
      add(1'b1, 8'hFF, 1'b0, mk(oh(nx), nx, 1'b1, 1'b0));
    end
    add(1'b1, 8'hFF, 1'b1, mk(8'h00, 3'd0, 1'b0, 1'b0));
    // Single requester 3, released by Done on its third cycle; Ptr -> 4.
    add(1'b1, 8'b00010000, 1'b0, mk(8'b00010000, 3'd3, 1'b1, 1'b0));
    add(1'b1, 8'b00010000, 1'b0, mk(8'b00010000, 3'd3, 1'b1, 1'b0));
    add(1'b1, 8'b00010000, 1'b0, mk(8'b00010000, 3'd3, 1'b1, 1'b0));
    add(1'b1, 8'b00010000, 1'b1, mk(8'h00, 3'd3, 1'b0, 1'b0));
    // Owner 6 then wrap through 7 and 0 to reach 1.
    add(1'b1, 8'b01000010, 1'b0, mk(8'b00000010, 3'd6, 1'b1, 1'b0));
    add(1'b1, 8'b01000010, 1'b1, mk(8'h00, 3'd6, 1'b0, 1'b0));
    add(1'b1, 8'b01000010, 1'b0, mk(8'b01000000, 3'd1, 1'b1, 1'b0));
    add(1'b1, 8'b01000010, 1'b1, mk(8'h00, 3'd1, 1'b0, 1'b0));
    // Reset in the second grant cycle of requester 5; Ptr returns to 0.
    add(1'b1, 8'b00000100, 1'b0, mk(8'b00000100, 3'd5, 1'b1, 1'b0));
    add(1'b1, 8'b00000100, 1'b0, mk(8'b00000100, 3'd5, 1'b1, 1'b0));
    add(1'b0, 8'b00000100, 1'b0, mk(8'h00, 3'd0, 1'b0, 1'b0));
    add(1'b1, 8'b01000100, 1'b0, mk(8'b01000000, 3'd1, 1'b1, 1'b0));
    add(1'b1, 8'b01000100, 1'b1, mk(8'h00, 3'd1, 1'b0, 1'b0));
    // Owner dropping its request releases without Timeout.
    add(1'b1, 8'b00100000, 1'b0, mk(8'b00100000, 3'd2, 1'b1, 1'b0));
    add(1'b1, 8'b00000001, 1'b0, mk(8'h00, 3'd2, 1'b0, 1'b0));
    add(1'b1, 8'b00000001, 1'b0, mk(8'b00000001, 3'd7, 1'b1, 1'b0));
    add(1'b1, 8'b00000001, 1'b1, mk(8'h00, 3'd7, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive_a(tbl[i].rstn, tbl[i].r, tbl[i].done, 1'b1, tbl[i].e);
      tick();
    end

    // Hold limit of 4 on requester 2, regrant, then Done together with the limit.
    drive_b(1'b0, 8'h00, 1'b0, 1'b1, z); tick();
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 8'b00100000, 1'b0, 1'b1, mk(8'b00100000, 3'd2, 1'b1, 1'b0));
      tick();
    end
    drive_b(1'b1, 8'b00100000, 1'b0, 1'b1, mk(8'h00, 3'd2, 1'b0, 1'b1)); tick();
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 8'b00100000, 1'b0, 1'b1, mk(8'b00100000, 3'd2, 1'b1, 1'b0));
      tick();
    end
    drive_b(1'b1, 8'b00100000, 1'b1, 1'b1, mk(8'h00, 3'd2, 1'b0, 1'b0)); tick();
    drive_b(1'b1, 8'h00, 1'b0, 1'b1, mk(8'h00, 3'd2, 1'b0, 1'b0)); tick();

    // Random traffic on all instances against the reference model.
    drive_a(1'b0, 8'h00, 1'b0, 1'b0, z);
    drive_b(1'b0, 8'h00, 1'b0, 1'b0, z);
    tick();
    for (int i = 0; i < 600; i++) begin
      drive_a(($urandom_range(63) != 0),
              ($urandom_range(5) == 0) ? 8'($urandom) : r_a,
              ($urandom_range(7) == 0), 1'b0, z);
      drive_b(($urandom_range(63) != 0),
              ($urandom_range(3) == 0) ? 8'($urandom) : r_b,
              ($urandom_range(4) == 0), 1'b0, z);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
